// File: rtl/mux_scan_nch.sv
// mux_scan_nch: registered N:1 channel mux with manual select and auto-scan dwell mode.
// Define MUX_SCAN_MASK_EN to add a ch_mask input that skips disabled channels.
module mux_scan_nch #(
  parameter int NCH = 4,
  parameter int W = 1,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH*W-1:0] a,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NCH-1:0]  ch_mask,
`endif
  output logic [W-1:0]    y,
  output logic [SELW-1:0] y_sel,
  output logic            y_valid,
  output logic            chg,
  output logic            sel_err
);
  localparam int CW = $clog2(DWELL) + 1;
  localparam int NS = 2 ** SELW;
  typedef enum logic {MANUAL, SCAN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SELW-1:0] ptr, nxt, idx;
  logic [W-1:0] ch [NS];
  logic [NCH-1:0] en;
  logic [NS-1:0] en_ext;
  logic ok, any, expire;
`ifdef MUX_SCAN_MASK_EN
  assign en = ch_mask;
`else
  assign en = '1;
`endif
  // Pad the channel table to a power of two so any sel value indexes safely.
  for (genvar i = 0; i < NS; i++) begin : g_ch
    if (i < NCH) begin : g_in
      assign ch[i] = a[i*W +: W];
    end else begin : g_pad
      assign ch[i] = '0;
    end
  end
  always_comb begin
    en_ext = NS'(en);
    ok = en_ext[sel];
    any = |en;
    expire = cnt == CW'(DWELL - 1);
    idx = '0;
    nxt = ptr;
    // Descending search so the nearest enabled channel above ptr wins.
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(ptr) + k >= NCH) ? SELW'(int'(ptr) + k - NCH) : SELW'(int'(ptr) + k);
      if (en_ext[idx]) nxt = idx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MANUAL;
      cnt <= '0;
      ptr <= '0;
      y <= '0;
      y_sel <= '0;
      y_valid <= 1'b0;
      chg <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      y_valid <= 1'b1;
      if (!mode) begin
        state <= MANUAL;
        cnt <= '0;
        y <= ok ? ch[sel] : '0;
        y_sel <= ok ? sel : y_sel;
        chg <= ok && sel != y_sel;
        sel_err <= !ok;
      end else if (state == MANUAL) begin
        state <= SCAN;
        cnt <= '0;
        ptr <= y_sel;
        y <= any ? ch[y_sel] : '0;
        chg <= 1'b0;
        sel_err <= 1'b0;
      end else begin
        cnt <= expire ? '0 : cnt + 1'b1;
        sel_err <= 1'b0;
        if (expire && any) begin
          ptr <= nxt;
          y_sel <= nxt;
          y <= ch[nxt];
          chg <= nxt != y_sel;
        end else begin
          y <= any ? ch[ptr] : '0;
          chg <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/mux_scan_nch.md
Name: mux_scan_nch

Overview:
- Parametrised, registered N:1 channel multiplexer; successor to the fixed 4:1 combinational mux.
- Two modes:
  - Manual: an external select picks the channel.
  - Auto-scan: the block steps through all channels, holding each for a programmable dwell time.
- Drives downstream sampling/display logic with registered data, the current channel index and a change strobe.

Parameters:
- NCH, 4, number of input channels (2..16).
- W, 1, data width per channel in bits.
- DWELL, 4, clock cycles each channel is held in scan mode (>=1).
- SELW (localparam), $clog2(NCH), select/index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- a  input  NCH*W  packed channel data; channel k occupies a[k*W +: W].
- sel  input  SELW  manual channel select.
- mode  input  1  0 = manual, 1 = auto-scan.
- y  output  W  registered selected data.
- y_sel  output  SELW  index of the channel currently driven on y.
- y_valid  output  1  high once the output register holds valid data after reset.
- chg  output  1  one-cycle pulse when y_sel changes value.
- sel_err  output  1  registered; high while manual sel >= NCH.

Behaviour:
- Reset (async, rst=1):
  - y=0, y_sel=0, y_valid=0, chg=0, sel_err=0.
  - Dwell counter 0, scan pointer 0, state MANUAL.
- Release: first rising edge with rst=0 loads the output registers and sets y_valid=1. y_valid stays 1 until the next reset.
- Latency: 1 cycle. Values sampled on a, sel and mode at edge n appear on y and y_sel after edge n.
- FSM states: MANUAL, SCAN.
  - MANUAL -> SCAN when mode=1 at an edge.
    - Pointer loads the current y_sel; the counter clears.
    - The first dwell on that channel is a full DWELL cycles.
  - SCAN -> MANUAL when mode=0 at an edge.
    - That same edge loads y and y_sel from sel; the counter clears.
- MANUAL:
  - If sel < NCH: y <= a[sel], y_sel <= sel, sel_err <= 0.
  - If sel >= NCH (non-power-of-2 NCH): y <= 0, y_sel holds, sel_err <= 1.
- SCAN:
  - y <= a[ptr] every cycle, so data changes on the held channel are tracked.
  - When counter == DWELL-1: counter <= 0, ptr <= ptr+1; ptr wraps from NCH-1 to 0.
  - Otherwise counter increments.
  - sel_err <= 0 in SCAN.
- chg:
  - Registered; 1 for exactly the cycle after an edge where the y_sel register changed value.
  - No chg on the reset-release load, since y_sel stays 0.
  - With DWELL=1, chg stays high continuously while scanning.
- Simultaneous events:
  - A mode change at the same edge as a dwell expiry: the mode change wins; ptr does not advance.
  - sel changes in SCAN are ignored.
- Reset mid-scan: immediate return to the reset values; the scan restarts from channel 0 only after mode is seen high again.
- Width rules: counter width is $clog2(DWELL)+1; no arithmetic overflow is possible.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds input ch_mask [NCH-1:0]; 1 = channel enabled.
  - SCAN advances to the next enabled channel in ascending order with wrap, skipping disabled ones in a single step.
  - If no channel is enabled: y=0, ptr and y_sel hold, and no chg.
  - MANUAL select of a disabled channel gives y=0 with sel_err=1.
  - If the current scan channel becomes disabled mid-dwell, it is left at the next dwell expiry.
- Not defined: no ch_mask port; all channels are always enabled; behaviour is exactly as above.

Test Plan (NCH=4, W=1, DWELL=4 unless noted):
1. Reset/basic manual: rst=1, then release with mode=0, a=4'b0001, sel=0.
   - During reset: y=0, y_valid=0.
   - One edge after release: y=1, y_valid=1, chg=0.
2. Manual walk: a=4'b0100, sel stepped 0,1,2,3 every 100 ns.
   - y = 0,0,1,0, each one cycle after its sel change.
   - chg pulses once per step; y_sel tracks sel.
3. Auto-scan wrap: a=4'b1000, mode=1 from y_sel=0.
   - y_sel sequence 0,1,2,3,0, each held 4 cycles.
   - y=1 only while y_sel=3; chg is a single-cycle pulse at each transition.
4. Scan to manual mid-dwell: switch mode to 0 on dwell cycle 2 of channel 2 with sel=1.
   - Next cycle: y_sel=1, y=a[1]; no further advance.
5. Async reset mid-scan: assert rst between clock edges during a scan.
   - Outputs clear immediately without waiting for a clock edge; y_valid=0.
6. Mask feature / bad select:
   - NCH=3, mode=0, sel=3 -> y=0, sel_err=1.
   - With MUX_SCAN_MASK_EN, ch_mask=4'b1010, scan -> y_sel sequence 1,3,1,3.
